sync_fifo: RTL and testbench



---
 rtl/fifo_pkg.sv | 10 +
 rtl/fifomem.sv | 19 +
 rtl/sync_fifo.sv | 102 ++++++++++
 tb/tb_sync_fifo.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared depth helper, default thresholds and read-mode encodings for the FIFOs
package fifo_pkg;
    localparam int MODE_STD          = 0;
    localparam int MODE_FWFT         = 1;
    localparam int DEF_AEMPTY_THRESH = 2;
    localparam int DEF_AFULL_MARGIN  = 2;
    function automatic int fifo_depth(input int addr_size);
        return 1 << addr_size;
    endfunction
endpackage

// File: rtl/fifomem.sv
// fifomem: dual-port RAM with synchronous write and asynchronous read
module fifomem #(
    parameter int DATA_SIZE = 8,
    parameter int ADDR_SIZE = 4
) (
    output logic [DATA_SIZE-1:0] rdata,
    input  logic [DATA_SIZE-1:0] wdata,
    input  logic [ADDR_SIZE-1:0] waddr,
    input  logic [ADDR_SIZE-1:0] raddr,
    input  logic                 wclken,
    input  logic                 wfull,
    input  logic                 wclk
);
    localparam int DEPTH = 1 << ADDR_SIZE;
    logic [DATA_SIZE-1:0] mem [DEPTH];
    assign rdata = mem[raddr];
    always_ff @(posedge wclk)
        if (wclken && !wfull) mem[waddr] <= wdata;
endmodule

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with count, almost flags, overflow/underflow pulses and optional FWFT reads
module sync_fifo
    import fifo_pkg::*;
#(
    parameter int DATA_SIZE     = 8,
    parameter int ADDR_SIZE     = 4,
    parameter int AFULL_THRESH  = fifo_depth(ADDR_SIZE) - DEF_AFULL_MARGIN,
    parameter int AEMPTY_THRESH = DEF_AEMPTY_THRESH,
    parameter int FWFT          = MODE_STD
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [DATA_SIZE-1:0] wr_data,
    input  logic                 rd_en,
    output logic [DATA_SIZE-1:0] rd_data,
    output logic                 rd_valid,
    output logic                 full,
    output logic                 empty,
    output logic                 almost_full,
    output logic                 almost_empty,
    output logic [ADDR_SIZE:0]   count,
    output logic                 overflow,
    output logic                 underflow
);
    localparam int CW = ADDR_SIZE + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(fifo_depth(ADDR_SIZE));
    localparam logic [CW-1:0] AF_C    = CW'(AFULL_THRESH);
    localparam logic [CW-1:0] AE_C    = CW'(AEMPTY_THRESH);

    logic [CW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count_q, count_d;
    logic                 full_q, full_d, empty_q, empty_d;
    logic                 almost_full_q, almost_full_d, almost_empty_q, almost_empty_d;
    logic                 overflow_q, overflow_d, underflow_q, underflow_d;
    logic [DATA_SIZE-1:0] rd_data_q, rd_data_d, mem_rdata;
    logic                 rd_valid_q, rd_valid_d, wr_acc, rd_acc;

    fifomem #(.DATA_SIZE(DATA_SIZE), .ADDR_SIZE(ADDR_SIZE)) u_mem (
        .rdata (mem_rdata),
        .wdata (wr_data),
        .waddr (wr_ptr_q[ADDR_SIZE-1:0]),
        .raddr (rd_ptr_q[ADDR_SIZE-1:0]),
        .wclken(wr_acc),
        .wfull (full_q),
        .wclk  (clk)
    );

    always_comb begin
        wr_acc         = wr_en & ~full_q;
        rd_acc         = rd_en & ~empty_q;
        wr_ptr_d       = wr_acc ? wr_ptr_q + CW'(1) : wr_ptr_q;
        rd_ptr_d       = rd_acc ? rd_ptr_q + CW'(1) : rd_ptr_q;
        count_d        = (wr_acc & ~rd_acc) ? count_q + CW'(1) :
                         (rd_acc & ~wr_acc) ? count_q - CW'(1) : count_q;
        full_d         = count_d == DEPTH_C;
        empty_d        = count_d == '0;
        almost_full_d  = count_d >= AF_C;
        almost_empty_d = count_d <= AE_C;
        overflow_d     = wr_en & full_q;
        underflow_d    = rd_en & empty_q;
        rd_data_d      = rd_acc ? mem_rdata : rd_data_q;
        rd_valid_d     = rd_acc;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            full_q         <= 1'b0;
            empty_q        <= 1'b1;
            almost_full_q  <= AF_C == '0;
            almost_empty_q <= 1'b1;
            overflow_q     <= 1'b0;
            underflow_q    <= 1'b0;
            rd_data_q      <= '0;
            rd_valid_q     <= 1'b0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            full_q         <= full_d;
            empty_q        <= empty_d;
            almost_full_q  <= almost_full_d;
            almost_empty_q <= almost_empty_d;
            overflow_q     <= overflow_d;
            underflow_q    <= underflow_d;
            rd_data_q      <= rd_data_d;
            rd_valid_q     <= rd_valid_d;
        end
    end

    assign rd_data      = (FWFT == MODE_FWFT) ? (empty_q ? '0 : mem_rdata) : rd_data_q;
    assign rd_valid     = (FWFT == MODE_FWFT) ? ~empty_q : rd_valid_q;
    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = almost_full_q;
    assign almost_empty = almost_empty_q;
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;
endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: directed checks of a standard-mode and an FWFT-mode sync_fifo
module tb_sync_fifo;
    logic       clk = 1'b0, rst = 1'b0;
    logic [7:0] wr_data = '0;
    logic       s_wr_en = 1'b0, s_rd_en = 1'b0, f_wr_en = 1'b0, f_rd_en = 1'b0;
    logic [7:0] s_rd_data, f_rd_data;
    logic [4:0] s_count, f_count;
    logic       s_rd_valid, s_full, s_empty, s_afull, s_aempty, s_ovf, s_unf;
    logic       f_rd_valid, f_full, f_empty, f_afull, f_aempty, f_ovf, f_unf;
    int         compared = 0, mismatched = 0;

    always #5 clk = ~clk;

    sync_fifo #(.DATA_SIZE(8), .ADDR_SIZE(4), .AFULL_THRESH(14), .AEMPTY_THRESH(2), .FWFT(0)) u_std (
        .clk(clk), .rst(rst), .wr_en(s_wr_en), .wr_data(wr_data), .rd_en(s_rd_en),
        .rd_data(s_rd_data), .rd_valid(s_rd_valid), .full(s_full), .empty(s_empty),
        .almost_full(s_afull), .almost_empty(s_aempty), .count(s_count),
        .overflow(s_ovf), .underflow(s_unf)
    );

    sync_fifo #(.DATA_SIZE(8), .ADDR_SIZE(4), .AFULL_THRESH(14), .AEMPTY_THRESH(2), .FWFT(1)) u_fw (
        .clk(clk), .rst(rst), .wr_en(f_wr_en), .wr_data(wr_data), .rd_en(f_rd_en),
        .rd_data(f_rd_data), .rd_valid(f_rd_valid), .full(f_full), .empty(f_empty),
        .almost_full(f_afull), .almost_empty(f_aempty), .count(f_count),
        .overflow(f_ovf), .underflow(f_unf)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        compared++;
        if ({s_empty, s_full, s_count, s_aempty, s_afull, s_rd_valid, s_rd_data, s_ovf, s_unf} !== {1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0}) begin
            mismatched++;
            $display("FAIL reset_std: empty=%b full=%b count=%0d ae=%b af=%b valid=%b data=%h ovf=%b unf=%b, need 1 0 0 1 0 0 00 0 0",
                     s_empty, s_full, s_count, s_aempty, s_afull, s_rd_valid, s_rd_data, s_ovf, s_unf);
        end
        compared++;
        if ({f_empty, f_full, f_count, f_aempty, f_afull, f_rd_valid, f_rd_data} !== {1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 8'h00}) begin
            mismatched++;
            $display("FAIL reset_fwft: empty=%b full=%b count=%0d ae=%b af=%b valid=%b data=%h, need 1 0 0 1 0 0 00",
                     f_empty, f_full, f_count, f_aempty, f_afull, f_rd_valid, f_rd_data);
        end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 16; i++) begin
            s_wr_en = 1'b1;
            wr_data = 8'(i);
            tick();
            compared++;
            if ({s_count, s_full, s_empty, s_afull, s_aempty} !== {5'(i + 1), i == 15, 1'b0, i >= 13, i <= 1}) begin
                mismatched++;
                $display("FAIL fill_%0d: count=%0d full=%b empty=%b af=%b ae=%b, need count=%0d full=%b empty=0 af=%b ae=%b",
                         i, s_count, s_full, s_empty, s_afull, s_aempty, i + 1, i == 15, i >= 13, i <= 1);
            end
        end
        s_wr_en = 1'b0;
    endtask

    task automatic test_overflow();
        s_wr_en = 1'b1;
        wr_data = 8'hAA;
        tick();
        s_wr_en = 1'b0;
        compared++;
        if ({s_ovf, s_count, s_full} !== {1'b1, 5'd16, 1'b1}) begin
            mismatched++;
            $display("FAIL overflow_pulse: ovf=%b count=%0d full=%b, need 1 16 1", s_ovf, s_count, s_full);
        end
        tick();
        compared++;
        if ({s_ovf, s_count} !== {1'b0, 5'd16}) begin
            mismatched++;
            $display("FAIL overflow_end: ovf=%b count=%0d, need 0 16", s_ovf, s_count);
        end
    endtask

    task automatic test_drain();
        for (int i = 0; i < 16; i++) begin
            s_rd_en = 1'b1;
            tick();
            compared++;
            if ({s_rd_valid, s_rd_data, s_count, s_aempty, s_afull} !== {1'b1, 8'(i), 5'(15 - i), i >= 13, i <= 1}) begin
                mismatched++;
                $display("FAIL drain_%0d: valid=%b data=%h count=%0d ae=%b af=%b, need 1 %h %0d %b %b",
                         i, s_rd_valid, s_rd_data, s_count, s_aempty, s_afull, 8'(i), 15 - i, i >= 13, i <= 1);
            end
        end
        s_rd_en = 1'b0;
        tick();
        compared++;
        if ({s_rd_valid, s_rd_data, s_empty, s_unf} !== {1'b0, 8'h0F, 1'b1, 1'b0}) begin
            mismatched++;
            $display("FAIL drain_idle: valid=%b data=%h empty=%b unf=%b, need 0 0f 1 0", s_rd_valid, s_rd_data, s_empty, s_unf);
        end
    endtask

    task automatic test_simultaneous();
        s_wr_en = 1'b1;
        s_rd_en = 1'b1;
        wr_data = 8'h33;
        tick();
        s_rd_en = 1'b0;
        compared++;
        if ({s_unf, s_count, s_rd_valid, s_empty} !== {1'b1, 5'd1, 1'b0, 1'b0}) begin
            mismatched++;
            $display("FAIL both_empty: unf=%b count=%0d valid=%b empty=%b, need 1 1 0 0", s_unf, s_count, s_rd_valid, s_empty);
        end
        for (int i = 0; i < 15; i++) begin
            wr_data = 8'h40 + 8'(i);
            tick();
        end
        compared++;
        if ({s_unf, s_full, s_count} !== {1'b0, 1'b1, 5'd16}) begin
            mismatched++;
            $display("FAIL refill: unf=%b full=%b count=%0d, need 0 1 16", s_unf, s_full, s_count);
        end
        s_rd_en = 1'b1;
        wr_data = 8'hBB;
        tick();
        s_wr_en = 1'b0;
        compared++;
        if ({s_ovf, s_count, s_full, s_rd_valid, s_rd_data} !== {1'b1, 5'd15, 1'b0, 1'b1, 8'h33}) begin
            mismatched++;
            $display("FAIL both_full: ovf=%b count=%0d full=%b valid=%b data=%h, need 1 15 0 1 33",
                     s_ovf, s_count, s_full, s_rd_valid, s_rd_data);
        end
        for (int i = 0; i < 15; i++) begin
            tick();
            compared++;
            if ({s_rd_data, s_count} !== {8'h40 + 8'(i), 5'(14 - i)}) begin
                mismatched++;
                $display("FAIL drain2_%0d: data=%h count=%0d, need %h %0d", i, s_rd_data, s_count, 8'h40 + 8'(i), 14 - i);
            end
        end
        s_rd_en = 1'b0;
        tick();
    endtask

    task automatic test_wrap();
        s_wr_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wr_data = 8'h80 + 8'(i);
            tick();
        end
        s_rd_en = 1'b1;
        for (int i = 0; i < 40; i++) begin
            wr_data = 8'h83 + 8'(i);
            tick();
            compared++;
            if ({s_rd_valid, s_rd_data, s_count, s_full} !== {1'b1, 8'h80 + 8'(i), 5'd3, 1'b0}) begin
                mismatched++;
                $display("FAIL wrap_%0d: valid=%b data=%h count=%0d full=%b, need 1 %h 3 0",
                         i, s_rd_valid, s_rd_data, s_count, s_full, 8'h80 + 8'(i));
            end
        end
        s_wr_en = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        s_rd_en = 1'b0;
        compared++;
        if ({s_rd_data, s_empty} !== {8'hAA, 1'b1}) begin
            mismatched++;
            $display("FAIL wrap_tail: data=%h empty=%b, need aa 1", s_rd_data, s_empty);
        end
    endtask

    task automatic test_fwft();
        f_wr_en = 1'b1;
        wr_data = 8'h5A;
        tick();
        f_wr_en = 1'b0;
        compared++;
        if ({f_rd_valid, f_rd_data, f_count, f_empty} !== {1'b1, 8'h5A, 5'd1, 1'b0}) begin
            mismatched++;
            $display("FAIL fwft_present: valid=%b data=%h count=%0d empty=%b, need 1 5a 1 0", f_rd_valid, f_rd_data, f_count, f_empty);
        end
        f_rd_en = 1'b1;
        tick();
        f_rd_en = 1'b0;
        compared++;
        if ({f_empty, f_rd_valid, f_count} !== {1'b1, 1'b0, 5'd0}) begin
            mismatched++;
            $display("FAIL fwft_pop: empty=%b valid=%b count=%0d, need 1 0 0", f_empty, f_rd_valid, f_count);
        end
    endtask

    task automatic test_reset_mid();
        f_wr_en = 1'b1;
        for (int i = 0; i < 7; i++) begin
            wr_data = 8'h10 + 8'(i);
            tick();
        end
        compared++;
        if ({f_count, f_rd_data} !== {5'd7, 8'h10}) begin
            mismatched++;
            $display("FAIL burst: count=%0d data=%h, need 7 10", f_count, f_rd_data);
        end
        rst = 1'b0;
        tick();
        rst = 1'b1;
        f_wr_en = 1'b0;
        compared++;
        if ({f_count, f_empty, f_rd_valid} !== {5'd0, 1'b1, 1'b0}) begin
            mismatched++;
            $display("FAIL mid_reset: count=%0d empty=%b valid=%b, need 0 1 0", f_count, f_empty, f_rd_valid);
        end
        f_wr_en = 1'b1;
        wr_data = 8'h77;
        tick();
        f_wr_en = 1'b0;
        compared++;
        if ({f_rd_valid, f_rd_data, f_count} !== {1'b1, 8'h77, 5'd1}) begin
            mismatched++;
            $display("FAIL post_reset_write: valid=%b data=%h count=%0d, need 1 77 1", f_rd_valid, f_rd_data, f_count);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_overflow();
        test_drain();
        test_simultaneous();
        test_wrap();
        test_fwft();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
